// File: rtl/cmp_pkg.sv
// Shared constants for the sequential magnitude comparator: FSM encoding and
// an elaboration-time log2 helper.
package cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice, built from gate
// primitives as an MSB-first equality-prefix cascade.
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             eq
);

  // Bit i decides gt only when every higher bit already matched.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    wire w_pre_in;
    wire w_acc_in;
    wire w_bit_eq;
    wire w_y_n;
    wire w_term;
    wire w_pre_o;
    wire w_acc_o;

    if (i == DIGIT - 1) begin : g_msb
      assign w_pre_in = 1'b1;
      assign w_acc_in = 1'b0;
    end else begin : g_low
      assign w_pre_in = g_bit[i+1].w_pre_o;
      assign w_acc_in = g_bit[i+1].w_acc_o;
    end

    xnor u_xnor (w_bit_eq, x[i], y[i]);
    not  u_not  (w_y_n, y[i]);
    and  u_term (w_term, w_pre_in, x[i], w_y_n);
    and  u_pre  (w_pre_o, w_pre_in, w_bit_eq);
    or   u_acc  (w_acc_o, w_acc_in, w_term);
  end

  assign gt = g_bit[0].w_acc_o;
  assign eq = g_bit[0].w_pre_o;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit, unsigned or
// two's-complement, behind valid/ready handshakes on both sides.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned IDX_W      = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             r_start_ready;
  logic             r_res_valid;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_op_a_nxt;
  logic [WIDTH-1:0] w_op_b_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_gt_nxt;
  logic             w_eq_nxt;
  logic             w_lt_nxt;
  logic             w_start_ready_nxt;
  logic             w_res_valid_nxt;

  logic [WIDTH-1:0] w_sign_mask;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic             w_dig_gt;
  logic             w_dig_eq;

  // Flipping the sign bit maps two's-complement onto offset binary.
  assign w_sign_mask = signed_mode ? SIGN_BIT : '0;

  assign w_a_dig = DIGIT'(r_op_a >> (32'(r_idx) * DIGIT));
  assign w_b_dig = DIGIT'(r_op_b >> (32'(r_idx) * DIGIT));

  cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
    .x  (w_a_dig),
    .y  (w_b_dig),
    .gt (w_dig_gt),
    .eq (w_dig_eq)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_op_a_nxt        = r_op_a;
    w_op_b_nxt        = r_op_b;
    w_idx_nxt         = r_idx;
    w_gt_nxt          = r_gt;
    w_eq_nxt          = r_eq;
    w_lt_nxt          = r_lt;
    w_start_ready_nxt = r_start_ready;
    w_res_valid_nxt   = r_res_valid;

    case (r_state)
      ST_IDLE: begin
        if (start_valid && r_start_ready) begin
          w_op_a_nxt        = a ^ w_sign_mask;
          w_op_b_nxt        = b ^ w_sign_mask;
          w_idx_nxt         = IDX_W'(NUM_DIGITS - 1);
          w_start_ready_nxt = 1'b0;
          w_state_nxt       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!w_dig_eq) begin
          w_gt_nxt        = w_dig_gt;
          w_lt_nxt        = ~w_dig_gt;
          w_eq_nxt        = 1'b0;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else if (r_idx == '0) begin
          w_gt_nxt        = 1'b0;
          w_lt_nxt        = 1'b0;
          w_eq_nxt        = 1'b1;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          w_res_valid_nxt   = 1'b0;
          w_start_ready_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end
      end
      default: begin
        w_res_valid_nxt   = 1'b0;
        w_start_ready_nxt = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_idx         <= '0;
      r_gt          <= 1'b0;
      r_eq          <= 1'b0;
      r_lt          <= 1'b0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_op_a        <= w_op_a_nxt;
      r_op_b        <= w_op_b_nxt;
      r_idx         <= w_idx_nxt;
      r_gt          <= w_gt_nxt;
      r_eq          <= w_eq_nxt;
      r_lt          <= w_lt_nxt;
      r_start_ready <= w_start_ready_nxt;
      r_res_valid   <= w_res_valid_nxt;
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign a_gt_b      = r_gt;
  assign a_eq_b      = r_eq;
  assign a_lt_b      = r_lt;

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands, with unsigned and two's-complement modes.
- Scans MSB-first, DIGIT bits per cycle, and stops early at the first unequal digit.
- Produces one-hot gt/eq/lt flags.
- Valid/ready handshakes on the operand and result sides so it sits between datapath stages without external sequencing glue.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits compared per SCAN cycle. Must satisfy 1 <= DIGIT <= WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operands and mode are valid.
- start_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- res_valid  out  1  result flags valid.
- res_ready  in  1  consumer accepts result.
- a_gt_b  out  1  A > B.
- a_eq_b  out  1  A == B.
- a_lt_b  out  1  A < B.

Behaviour:
- Clock and reset: one clock (clk), rising edge. Reset (rst) is synchronous and active-high, and overrides every other input.
- Reset values:
  - state = IDLE, start_ready = 1, res_valid = 0.
  - a_gt_b = a_eq_b = a_lt_b = 0.
  - Internal operand and index registers = 0.
- Derived constant: NUM_DIGITS = WIDTH/DIGIT. Digit index width is clog2(NUM_DIGITS), minimum 1.
- IDLE:
  - start_ready = 1.
  - Accept occurs on an edge where start_valid & start_ready.
  - On accept: latch a and b into op_a and op_b. If signed_mode = 1, invert bit WIDTH-1 of both latched operands (offset-binary mapping), so the remainder of the compare is unsigned.
  - On accept: idx <= NUM_DIGITS-1, then go to SCAN.
  - Without accept: stay in IDLE; flags hold their last values.
- SCAN:
  - start_ready = 0. Each cycle, compare op_a digit idx (bits idx*DIGIT+DIGIT-1 : idx*DIGIT) with op_b digit idx, unsigned.
  - Digits unequal: load gt/lt from the digit compare, eq <= 0, go to DONE (early termination).
  - Digits equal and idx == 0: eq <= 1, gt <= 0, lt <= 0, go to DONE.
  - Digits equal and idx > 0: idx <= idx-1, stay in SCAN.
- DONE:
  - res_valid = 1, start_ready = 0.
  - Flags are exactly one-hot and stable.
  - On res_valid & res_ready, go to IDLE.
  - A new start can be accepted no earlier than the cycle after the result handshake (no same-cycle turnaround).
- Latency: k clock edges from the accept edge to res_valid high, where k = number of digits examined, 1..NUM_DIGITS. Throughput is at most one compare per k+2 cycles.
- Flags:
  - Registered; updated only on the SCAN-to-DONE transition.
  - Held after the result handshake until the next result.
  - Meaningful only while res_valid = 1.
- Input stability: a, b and signed_mode are sampled only at the accept edge. Changes at any other time have no effect.
- Reset mid-operation: in SCAN or DONE, the edge with rst = 1 forces the reset values. Any pending result is discarded and no res_valid pulse is produced.
- Boundary cases:
  - DIGIT == WIDTH: single-cycle SCAN, latency 1.
  - DIGIT == 1: pure bit-serial, latency up to WIDTH.
  - Signed most-negative versus most-positive (0x8000 vs 0x7FFF at WIDTH=16) must give lt.
- Assertions (bench-side):
  - Flags are one-hot whenever res_valid = 1.
  - start_ready and res_valid are never both high.

Decomposition:
- Shared package/header cmp_pkg:
  - FSM state encoding constants ST_IDLE, ST_SCAN, ST_DONE (2-bit).
  - clog2 helper function.
- One combinational sub-module, cmp_digit, parametrised by DIGIT:
  - Inputs x and y.
  - Outputs gt and eq (lt = ~gt & ~eq).
  - Built structurally from the existing gate primitives (xnor/and/or), using the cascaded equality-prefix scheme.
- The FSM, operand registers and index counter live in the top module.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4.
1. Unsigned, a=0x1234, b=0x0234: first digit differs, so res_valid rises 1 edge after accept with gt=1, eq=0, lt=0.
2. Unsigned, a=b=0xABCD: res_valid rises 4 edges after accept with eq=1. Then a=0x1230, b=0x1231 gives lt=1 after 4 edges.
3. a=0xFFFF, b=0x0001: with signed_mode=1, lt=1. With signed_mode=0, gt=1. With signed_mode=1, a=0x8000 vs b=0x7FFF gives lt=1.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE.
   - res_valid and flags are held stable, start_ready=0, and a start_valid pulse during this window is ignored.
   - After the handshake, start_ready=1 on the next cycle and the next operands are accepted.
5. Reset mid-SCAN: a=b=0x0000, assert rst on the 2nd SCAN cycle.
   - Next cycle: state IDLE, start_ready=1, res_valid=0, all flags 0.
   - No result appears afterwards.
6. Change a and b every cycle during SCAN after accepting a=0x00FF, b=0x00FE: the result is still gt=1 after 4 edges, proving operands are sampled only at accept.
